// File: rtl/iob_plic_vec.sv
// Vectored PLIC: level/edge gateways with saturating edge counters, registered per-target arbitration and claim/complete over IOb; IOB_PLIC_VEC_THRESHOLD_EN adds threshold registers.
// Read data one cycle after request and no wait states; src_i to irq_o is 3 cycles, and a register write reaches best_id 2 cycles later.
module iob_plic_vec #(
    parameter int N_SOURCES         = 16,
    parameter int N_TARGETS         = 2,
    parameter int PRIORITIES        = 8,
    parameter int MAX_PENDING_COUNT = 4,
    parameter int ADDR_W            = 10,
    parameter int DATA_W            = 32,
    localparam int ID_W             = $clog2(N_SOURCES + 1),
    localparam int PRIO_W           = $clog2(PRIORITIES)
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      cke_i,
    input  logic                      iob_avalid_i,
    input  logic [ADDR_W-1:0]         iob_addr_i,
    input  logic [DATA_W-1:0]         iob_wdata_i,
    input  logic [DATA_W/8-1:0]       iob_wstrb_i,
    output logic                      iob_rvalid_o,
    output logic [DATA_W-1:0]         iob_rdata_o,
    output logic                      iob_ready_o,
    input  logic [N_SOURCES-1:0]      src_i,
    output logic [N_TARGETS-1:0]      irq_o,
    output logic [N_TARGETS*ID_W-1:0] irq_id_o
);
    localparam int CNT_W = $clog2(MAX_PENDING_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING_COUNT);

    logic [N_SOURCES:1]                 src_q, src_qq, rise, edge_mode, insvc, pending;
    logic [N_SOURCES:1]                 claim_hit, cpl_hit;
    logic [N_SOURCES:1][PRIO_W-1:0]     prio;
    logic [N_SOURCES:1][CNT_W-1:0]      cnt;
    logic [N_TARGETS-1:0][N_SOURCES:1]  en;
    logic [N_TARGETS-1:0][PRIO_W-1:0]   thr;
    logic [N_TARGETS-1:0][ID_W-1:0]     best_id, best_nxt;
    logic [N_TARGETS-1:0]               tgt_hit;
    logic [ID_W-1:0]                    claim_id;
    logic [DATA_W-1:0]                  rd_val;
    logic                               ready_q, rd, wr, claim, cpl, in_map;
    logic                               sel_prio, sel_pend, sel_edge, sel_tgt;
    logic [9:0]                         a;
    logic [4:0]                         src_idx;
    logic [2:0]                         tgt;
    logic [1:0]                         sub;
    logic                               unused_bits;

    assign unused_bits = ^{iob_wdata_i, iob_addr_i};

    assign a        = iob_addr_i[9:0];
    assign in_map   = (iob_addr_i >> 10) == '0;
    assign src_idx  = a[6:2];
    assign tgt      = a[6:4];
    assign sub      = a[3:2];
    assign sel_prio = in_map && (a[9:7] == 3'b000);
    assign sel_pend = in_map && (a[9:2] == 8'h20);
    assign sel_edge = in_map && (a[9:2] == 8'h21);
    assign sel_tgt  = in_map && (a[9:7] == 3'b010);

    assign rd    = cke_i && iob_avalid_i && ready_q && (iob_wstrb_i == '0);
    assign wr    = cke_i && iob_avalid_i && ready_q && (iob_wstrb_i != '0);
    assign claim = rd && (sub == 2'd2) && (|tgt_hit);
    assign cpl   = wr && (sub == 2'd2) && (|tgt_hit);
    assign rise  = src_q & ~src_qq;

    always_comb begin
        claim_id = '0;
        for (int t = 0; t < N_TARGETS; t++) begin
            tgt_hit[t] = sel_tgt && (tgt == 3'(t));
            if (tgt_hit[t]) claim_id = best_id[t];
        end
    end

    // A claim of ID 0 matches no source, so an empty claim is harmless.
    always_comb begin
        for (int k = 1; k <= N_SOURCES; k++) begin
            claim_hit[k] = claim && (claim_id == ID_W'(k));
            cpl_hit[k]   = cpl && (iob_wdata_i[ID_W-1:0] == ID_W'(k));
            pending[k]   = !insvc[k] && (edge_mode[k] ? (cnt[k] != '0) : src_qq[k]);
        end
    end

    always_comb begin
        rd_val = '0;
        if (sel_prio) begin
            for (int k = 1; k <= N_SOURCES; k++)
                if (src_idx == 5'(k)) rd_val[PRIO_W-1:0] = prio[k];
        end
        if (sel_pend) rd_val[N_SOURCES:1] = pending;
        if (sel_edge) rd_val[N_SOURCES:1] = edge_mode;
        for (int t = 0; t < N_TARGETS; t++) begin
            if (tgt_hit[t]) begin
                case (sub)
                    2'd0:    rd_val[N_SOURCES:1] = en[t];
                    2'd1:    rd_val[PRIO_W-1:0] = thr[t];
                    2'd2:    rd_val[ID_W-1:0] = best_id[t];
                    default: rd_val = '0;
                endcase
            end
        end
    end

    // Strict '>' against the running best gives lowest-ID tie-break and excludes priority <= threshold.
    always_comb begin
        logic [PRIO_W-1:0] bp;
        for (int t = 0; t < N_TARGETS; t++) begin
            best_nxt[t] = '0;
            bp = thr[t];
            for (int k = 1; k <= N_SOURCES; k++) begin
                if (pending[k] && en[t][k] && (prio[k] > bp)) begin
                    bp = prio[k];
                    best_nxt[t] = ID_W'(k);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            src_q  <= '0;
            src_qq <= '0;
            insvc  <= '0;
            cnt    <= '0;
        end else if (cke_i) begin
            src_q  <= src_i;
            src_qq <= src_q;
            for (int k = 1; k <= N_SOURCES; k++) begin
                if (claim_hit[k]) insvc[k] <= 1'b1;
                else if (cpl_hit[k]) insvc[k] <= 1'b0;
                if (edge_mode[k]) begin
                    if (rise[k] && !claim_hit[k] && (cnt[k] != CNT_MAX))
                        cnt[k] <= cnt[k] + 1'b1;
                    else if (!rise[k] && claim_hit[k] && (cnt[k] != '0))
                        cnt[k] <= cnt[k] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            prio      <= '0;
            edge_mode <= '0;
            en        <= '0;
            best_id   <= '0;
        end else if (cke_i) begin
            best_id <= best_nxt;
            if (wr && sel_prio) begin
                for (int k = 1; k <= N_SOURCES; k++)
                    if (src_idx == 5'(k)) prio[k] <= iob_wdata_i[PRIO_W-1:0];
            end
            if (wr && sel_edge) edge_mode <= iob_wdata_i[N_SOURCES:1];
            for (int t = 0; t < N_TARGETS; t++)
                if (wr && tgt_hit[t] && (sub == 2'd0)) en[t] <= iob_wdata_i[N_SOURCES:1];
        end
    end

`ifdef IOB_PLIC_VEC_THRESHOLD_EN
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            thr <= '0;
        end else if (cke_i) begin
            for (int t = 0; t < N_TARGETS; t++)
                if (wr && tgt_hit[t] && (sub == 2'd1)) thr[t] <= iob_wdata_i[PRIO_W-1:0];
        end
    end
`else
    assign thr = '0;
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ready_q      <= 1'b0;
            iob_rvalid_o <= 1'b0;
            iob_rdata_o  <= '0;
        end else if (cke_i) begin
            ready_q      <= 1'b1;
            iob_rvalid_o <= rd;
            iob_rdata_o  <= rd ? rd_val : '0;
        end
    end

    assign iob_ready_o = ready_q;
    assign irq_id_o    = best_id;
    always_comb begin
        for (int t = 0; t < N_TARGETS; t++) irq_o[t] = (best_id[t] != '0);
    end

endmodule

// File: tb/tb_iob_plic_vec.sv
// Directed bench for iob_plic_vec: gateways, arbitration order, edge saturation, threshold, bogus completes, async reset.
`timescale 1ns/1ps
module tb_iob_plic_vec;
    localparam int NS  = 16;
    localparam int NT  = 2;
    localparam int IDW = 5;
`ifdef IOB_PLIC_VEC_THRESHOLD_EN
    localparam bit TH = 1'b1;
`else
    localparam bit TH = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              cke = 1'b1;
    logic              avalid = 1'b0;
    logic [9:0]        addr = '0;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              rvalid, ready;
    logic [31:0]       rdata;
    logic [NS-1:0]     src = '0;
    logic [NT-1:0]     irq;
    logic [NT*IDW-1:0] irq_id;
    int                checks = 0;
    int                failures = 0;
    logic [31:0]       d;

    iob_plic_vec dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .cke_i       (cke),
        .iob_avalid_i(avalid),
        .iob_addr_i  (addr),
        .iob_wdata_i (wdata),
        .iob_wstrb_i (wstrb),
        .iob_rvalid_o(rvalid),
        .iob_rdata_o (rdata),
        .iob_ready_o (ready),
        .src_i       (src),
        .irq_o       (irq),
        .irq_id_o    (irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] data);
        avalid = 1'b1; addr = a; wstrb = 4'h0;
        tick();
        check("rvalid", {31'b0, rvalid}, 32'd1);
        data = rdata;
        avalid = 1'b0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] v);
        avalid = 1'b1; addr = a; wdata = v; wstrb = 4'hf;
        tick();
        avalid = 1'b0; wstrb = 4'h0;
    endtask

    function automatic logic [31:0] id_of(input int t);
        logic [NT*IDW-1:0] v;
        v = irq_id >> (t * IDW);
        return {27'b0, v[IDW-1:0]};
    endfunction

    initial begin
        int oth [8];
        oth = '{32'h080, 32'h084, 32'h100, 32'h104, 32'h108, 32'h110, 32'h114, 32'h0F0};

        // Reset state
        #12;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", {30'b0, irq}, 32'd0);
        check("rst_irq_id", {22'b0, irq_id}, 32'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        tick();
        check("ready_after_rst", {31'b0, ready}, 32'd1);
        for (int k = 0; k <= NS; k++) begin
            rd(10'(4 * k), d);
            check("rst_prio_rd", d, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            rd(10'(oth[i]), d);
            check("rst_map_rd", d, 32'd0);
        end
        tick();
        check("rvalid_pulse", {31'b0, rvalid}, 32'd0);

        // Level source 3, prio 2, target 0
        wr(10'h00C, 32'd2);
        wr(10'h100, 32'h8);
        src[2] = 1'b1;
        ticks(2);
        check("lvl_irq_n2", {31'b0, irq[0]}, 32'd0);
        tick();
        check("lvl_irq_n3", {31'b0, irq[0]}, 32'd1);
        check("lvl_id_n3", id_of(0), 32'd3);
        rd(10'h108, d);
        check("lvl_claim", d, 32'd3);
        check("lvl_irq_claim_n1", {31'b0, irq[0]}, 32'd1);
        tick();
        check("lvl_irq_claim_n2", {31'b0, irq[0]}, 32'd0);
        wr(10'h108, 32'd3);
        check("lvl_irq_cpl_n1", {31'b0, irq[0]}, 32'd0);
        tick();
        check("lvl_irq_cpl_n2", {31'b0, irq[0]}, 32'd1);
        check("lvl_id_cpl_n2", id_of(0), 32'd3);
        rd(10'h108, d);
        check("lvl_reclaim", d, 32'd3);
        src[2] = 1'b0;
        ticks(3);
        wr(10'h108, 32'd3);

        // Arbitration: 9 (prio 6) first, then tie 2/7 at prio 5 by lowest ID
        wr(10'h008, 32'd5);
        wr(10'h01C, 32'd5);
        wr(10'h024, 32'd6);
        wr(10'h100, 32'h284);
        src[1] = 1'b1; src[6] = 1'b1; src[8] = 1'b1;
        ticks(4);
        check("arb_id_first", id_of(0), 32'd9);
        check("arb_t1_quiet", {31'b0, irq[1]}, 32'd0);
        rd(10'h108, d);
        check("arb_claim_9", d, 32'd9);
        tick();
        rd(10'h108, d);
        check("arb_claim_2", d, 32'd2);
        tick();
        rd(10'h108, d);
        check("arb_claim_7", d, 32'd7);
        tick();
        check("arb_irq_drained", {31'b0, irq[0]}, 32'd0);
        src[1] = 1'b0; src[6] = 1'b0; src[8] = 1'b0;
        ticks(3);
        wr(10'h108, 32'd9);
        wr(10'h108, 32'd2);
        wr(10'h108, 32'd7);

        // Edge source 4: 6 pulses saturate at 4
        wr(10'h084, 32'h10);
        wr(10'h010, 32'd1);
        wr(10'h100, 32'h10);
        for (int i = 0; i < 6; i++) begin
            src[3] = 1'b1; tick();
            src[3] = 1'b0; tick();
        end
        ticks(3);
        rd(10'h080, d);
        check("edge_pending", d, 32'h10);
        for (int i = 0; i < 4; i++) begin
            rd(10'h108, d);
            check("edge_claim", d, 32'd4);
            wr(10'h108, 32'd4);
            ticks(2);
        end
        rd(10'h108, d);
        check("edge_claim_5th", d, 32'd0);
        tick();
        check("edge_irq_off", {31'b0, irq[0]}, 32'd0);

        // Threshold on target 1, source 5
        wr(10'h114, 32'd3);
        wr(10'h014, 32'd3);
        wr(10'h110, 32'h20);
        src[4] = 1'b1;
        ticks(4);
        check("thr_prio3", {31'b0, irq[1]}, {31'b0, !TH});
        rd(10'h114, d);
        check("thr_rd", d, TH ? 32'd3 : 32'd0);
        wr(10'h014, 32'd4);
        tick();
        check("thr_prio4", {31'b0, irq[1]}, 32'd1);
        check("thr_prio4_id", id_of(1), 32'd5);
        wr(10'h014, 32'd1);
        tick();
        check("thr_prio1", {31'b0, irq[1]}, {31'b0, !TH});
        wr(10'h014, 32'd4);
        tick();
        rd(10'h118, d);
        check("thr_claim_5", d, 32'd5);

        // Bogus completes while 3 and 5 are in service
        wr(10'h100, 32'h8);
        src[2] = 1'b1;
        ticks(4);
        rd(10'h108, d);
        check("svc_claim_3", d, 32'd3);
        wr(10'h108, 32'd6);
        wr(10'h108, 32'd0);
        wr(10'h118, 32'd17);
        ticks(2);
        check("bogus_cpl_irq", {30'b0, irq}, 32'd0);
        check("bogus_cpl_id", {22'b0, irq_id}, 32'd0);
        rd(10'h080, d);
        check("bogus_cpl_pend", d, 32'd0);

        // Async reset with read data in flight
        rd(10'h084, d);
        check("edge_reg_rd", d, 32'h10);
        #1 arst_n = 1'b0;
        #1;
        check("arst_rvalid", {31'b0, rvalid}, 32'd0);
        check("arst_rdata", rdata, 32'd0);
        check("arst_ready", {31'b0, ready}, 32'd0);
        check("arst_irq", {30'b0, irq}, 32'd0);
        check("arst_irq_id", {22'b0, irq_id}, 32'd0);
        #1 arst_n = 1'b1;
        ticks(3);
        rd(10'h080, d);
        check("post_rst_pend", d, 32'h28);
        rd(10'h084, d);
        check("post_rst_edge", d, 32'd0);
        rd(10'h00C, d);
        check("post_rst_prio", d, 32'd0);
        check("post_rst_irq", {30'b0, irq}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
